// File: rtl/ext_bus_apb_bridge.sv
// ext_bus_apb_bridge
//
// Turns a CPU-style multiplexed external bus access (row/column address,
// active-low CAS byte strobes, n_wait stretch) into a single APB transfer.
// The row address is taken on the falling edge of n_nren and becomes
// paddr[15:8]. Each CAS assertion inside the n_nren window becomes one APB
// transfer, and n_wait holds the CPU until the APB responder answers.
//
// Handshake: the CPU side is held by n_wait. n_wait goes low in the cycle
// psel rises and stays low until the APB transfer ends. The APB side follows
// standard SETUP/ACCESS sequencing: one cycle of psel alone, then psel+penable
// until pready=1. If pready does not arrive, the transfer ends after
// TIMEOUT_CYCLES ACCESS cycles. Once started, a transfer always finishes. Only
// n_rst can cut it short.
//
// Ports
//   clk, n_rst             clock, asynchronous active-low reset
//   bus_en                 external bus qualifier (low = ignore the bus)
//   n_nren                 active-low region select (transaction window)
//   n_cas_0, n_cas_1       active-low byte strobes (column phase)
//   n_we                   low = write
//   addr[10:0]             multiplexed row/column address
//   data_out[7:0]          write data from the CPU
//   data_in[7:0]           read data to the CPU
//   n_wait                 active-low wait to the CPU
//   paddr/pwdata/pwrite/psel/penable   APB initiator outputs
//   prdata/pready          APB responder returns
//   timeout_err            sticky, set when an ACCESS phase timed out
//   state_dbg[2:0]         current FSM state (IDLE=0 ROW=1 SETUP=2 ACCESS=3 DONE=4)

module ext_bus_apb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        bus_en,
  input  logic        n_nren,
  input  logic        n_cas_0,
  input  logic        n_cas_1,
  input  logic        n_we,
  input  logic [10:0] addr,
  input  logic [7:0]  data_out,
  output logic [7:0]  data_in,
  output logic        n_wait,
  output logic [15:0] paddr,
  output logic [7:0]  pwdata,
  output logic        pwrite,
  output logic        psel,
  output logic        penable,
  input  logic [7:0]  prdata,
  input  logic        pready,
  output logic        timeout_err,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ROW    = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  state_t     state;
  logic [7:0] cnt;
  logic       nren_q;

  // Only the low 8 address bits carry row/column information.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[10:8];

  assign state_dbg = state;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= S_IDLE;
      cnt         <= 8'd0;
      // Cleared so that a n_nren held low through reset does not count
      // as a falling edge. A fresh high->low transition is required.
      nren_q      <= 1'b0;
      paddr       <= 16'd0;
      pwdata      <= 8'd0;
      pwrite      <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      data_in     <= 8'd0;
      n_wait      <= 1'b1;
      timeout_err <= 1'b0;
    end else begin
      nren_q <= n_nren;
      case (state)
        S_IDLE: begin
          if (bus_en && nren_q && !n_nren) begin
            state       <= S_ROW;
            paddr[15:8] <= addr[7:0];
          end
        end
        S_ROW: begin
          if (!bus_en || n_nren) begin
            state <= S_IDLE;
          end else if (!n_cas_0 || !n_cas_1) begin
            state      <= S_SETUP;
            paddr[7:1] <= addr[7:1];
            // The upper byte lane alone selects the odd byte.
            paddr[0]   <= !n_cas_1 && n_cas_0;
            pwrite     <= ~n_we;
            pwdata     <= data_out;
            psel       <= 1'b1;
            n_wait     <= 1'b0;
          end
        end
        S_SETUP: begin
          state   <= S_ACCESS;
          penable <= 1'b1;
          cnt     <= 8'd1;
        end
        S_ACCESS: begin
          // If pready arrives in the last allowed cycle, it takes priority over the timeout.
          if (pready || cnt == TIMEOUT_LIM) begin
            state   <= S_DONE;
            psel    <= 1'b0;
            penable <= 1'b0;
            n_wait  <= 1'b1;
            if (!pwrite) data_in <= pready ? prdata : 8'hFF;
            if (!pready) timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE: begin
          if (n_cas_0 && n_cas_1) begin
            // Staying inside the n_nren window keeps the row address for the next CAS.
            state <= (!n_nren && bus_en) ? S_ROW : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_bus_apb_bridge.sv
module tb_ext_bus_apb_bridge;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        bus_en;
  logic        n_nren;
  logic        n_cas_0;
  logic        n_cas_1;
  logic        n_we;
  logic [10:0] addr;
  logic [7:0]  data_out;
  logic [7:0]  data_in;
  logic        n_wait;
  logic [15:0] paddr;
  logic [7:0]  pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [7:0]  prdata;
  logic        pready;
  logic        timeout_err;
  logic [2:0]  state_dbg;

  ext_bus_apb_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .n_rst(n_rst), .bus_en(bus_en), .n_nren(n_nren),
    .n_cas_0(n_cas_0), .n_cas_1(n_cas_1), .n_we(n_we), .addr(addr),
    .data_out(data_out), .data_in(data_in), .n_wait(n_wait), .paddr(paddr),
    .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .timeout_err(timeout_err),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // Entry layout: {pwrite, paddr[15:0], pwdata[7:0]}
  logic [24:0] exp_q[$];
  logic [24:0] obs_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          prot_err = 0;
  logic [10:0] cur_row;
  logic [24:0] held;

  // Monitor: record each transfer at SETUP and flag protocol breaks during ACCESS.
  always @(negedge clk) begin
    if (penable && !psel) prot_err++;
    if (psel && !penable) begin
      obs_q.push_back({pwrite, paddr, pwdata});
      held = {pwrite, paddr, pwdata};
    end else if (psel && penable && ({pwrite, paddr, pwdata} != held)) begin
      prot_err++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_row(input logic [10:0] row);
    n_nren  = 1'b0;
    addr    = row;
    cur_row = row;
    @(negedge clk);
  endtask

  // Drive one CAS access and answer it on APB. pready rises in ACCESS cycle
  // wait_n+1 when respond=1. Returns cycle counts seen from the CAS drive.
  task automatic do_cas(input logic [10:0] col, input bit use_cas1, input bit we,
                        input logic [7:0] wd, input int wait_n, input bit respond,
                        input logic [7:0] rd, input bit raise_nren,
                        output int psel_cyc, output int wait_cyc, output int acc,
                        output int t_psel, output int t_pen, output bit hung);
    int cyc;
    bit seen;
    psel_cyc = 0; wait_cyc = 0; acc = 0; t_psel = 0; t_pen = 0; hung = 1;
    cyc = 0; seen = 0;
    exp_q.push_back({we, cur_row[7:0], col[7:1], use_cas1, wd});
    addr = col; n_we = ~we; data_out = wd;
    if (use_cas1) n_cas_1 = 1'b0; else n_cas_0 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (psel) begin
        psel_cyc++;
        if (t_psel == 0) t_psel = cyc;
      end
      if (penable && t_pen == 0) t_pen = cyc;
      if (!n_wait) begin
        wait_cyc++;
        seen = 1;
      end
      if (penable) begin
        acc++;
        if (raise_nren && acc == 1) n_nren = 1'b1;
        pready = respond && (acc > wait_n);
        prdata = pready ? rd : 8'($urandom_range(0, 255));
      end else begin
        pready = 1'b0;
      end
      if (seen && n_wait) begin
        hung = 0;
        break;
      end
    end
    pready = 1'b0;
    n_cas_0 = 1'b1;
    n_cas_1 = 1'b1;
  endtask

  task automatic end_window();
    n_nren = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_rst = 1'b0; bus_en = 1'b1; n_nren = 1'b1; n_cas_0 = 1'b1; n_cas_1 = 1'b1;
    n_we = 1'b1; addr = '0; data_out = '0; prdata = '0; pready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({paddr, pwdata, pwrite, psel, penable} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_apb: got paddr=%h pwdata=%h pwrite=%b psel=%b penable=%b, expected all 0",
               paddr, pwdata, pwrite, psel, penable);
    end
    n_checks++;
    if (data_in !== 8'h00 || n_wait !== 1'b1 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cpu: got data_in=%h n_wait=%b timeout_err=%b, expected 00/1/0",
               data_in, n_wait, timeout_err);
    end
    n_checks++;
    if (state_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected 0", state_dbg);
    end
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_sb(input string name);
    logic [24:0] e, o;
    n_checks++;
    if (exp_q.size() == 0 || obs_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_sb: queue empty, exp=%0d obs=%0d entries", name, exp_q.size(), obs_q.size());
    end else begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s_sb: got {pwrite,paddr,pwdata}=%h expected %h", name, o, e);
      end
    end
  endtask

  task automatic test_write();
    int ps, wt, ac, tp, te; bit hung;
    start_row(11'h001);
    do_cas(11'h024, 0, 1, 8'h5A, 0, 1, 8'h00, 0, ps, wt, ac, tp, te, hung);
    n_checks++;
    if (hung || ps != 2 || wt != 2) begin
      n_fail++;
      $display("FAIL write_cycles: got hung=%0d psel=%0d n_wait_low=%0d expected 0/2/2", hung, ps, wt);
    end
    n_checks++;
    if (tp != 1 || te != 2) begin
      n_fail++;
      $display("FAIL write_latency: got psel@%0d penable@%0d expected 1/2", tp, te);
    end
    n_checks++;
    if (data_in !== 8'h00) begin
      n_fail++;
      $display("FAIL write_data_in: got %h expected 00 (unchanged)", data_in);
    end
    check_sb("write");
    n_nren = 1'b1;
    @(negedge clk);
    n_checks++;
    if (state_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL write_to_idle: got state %0d expected 0", state_dbg);
    end
    @(negedge clk);
  endtask

  task automatic test_read_wait();
    int ps, wt, ac, tp, te; bit hung;
    start_row(11'h002);
    do_cas(11'h006, 1, 0, 8'h00, 3, 1, 8'hC3, 0, ps, wt, ac, tp, te, hung);
    n_checks++;
    if (hung || wt != 5 || ac != 4) begin
      n_fail++;
      $display("FAIL read_wait_cycles: got hung=%0d n_wait_low=%0d access=%0d expected 0/5/4", hung, wt, ac);
    end
    n_checks++;
    if (data_in !== 8'hC3 || paddr !== 16'h0207) begin
      n_fail++;
      $display("FAIL read_wait_data: got data_in=%h paddr=%h expected C3/0207", data_in, paddr);
    end
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL read_wait_pready_wins: got timeout_err=%b expected 0", timeout_err);
    end
    check_sb("read_wait");
    end_window();
  endtask

  task automatic test_timeout();
    int ps, wt, ac, tp, te; bit hung;
    start_row(11'h033);
    do_cas(11'h080, 0, 0, 8'h00, 0, 0, 8'h00, 0, ps, wt, ac, tp, te, hung);
    n_checks++;
    if (hung || ac != TMO) begin
      n_fail++;
      $display("FAIL timeout_cycles: got hung=%0d access=%0d expected 0/%0d", hung, ac, TMO);
    end
    n_checks++;
    if (data_in !== 8'hFF || timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_result: got data_in=%h timeout_err=%b expected FF/1", data_in, timeout_err);
    end
    check_sb("timeout");
    end_window();
  endtask

  task automatic test_back_to_back();
    int ps, wt, ac, tp, te; bit hung;
    start_row(11'h0AB);
    do_cas(11'h010, 0, 1, 8'h11, 0, 1, 8'h00, 0, ps, wt, ac, tp, te, hung);
    @(negedge clk);
    n_checks++;
    if (hung || state_dbg !== 3'd1) begin
      n_fail++;
      $display("FAIL b2b_stay_row: got hung=%0d state=%0d expected 0/1", hung, state_dbg);
    end
    do_cas(11'h011, 1, 0, 8'h22, 1, 1, 8'h77, 0, ps, wt, ac, tp, te, hung);
    n_checks++;
    if (hung || data_in !== 8'h77) begin
      n_fail++;
      $display("FAIL b2b_read: got hung=%0d data_in=%h expected 0/77", hung, data_in);
    end
    check_sb("b2b_first");
    check_sb("b2b_second");
    n_checks++;
    if (timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: got timeout_err=%b expected 1", timeout_err);
    end
    end_window();
  endtask

  task automatic test_random();
    int ps, wt, ac, tp, te; bit hung;
    logic [10:0] row, col;
    logic [7:0] wd, rd;
    bit we, c1;
    int wn;
    for (int k = 0; k < 4; k++) begin
      row = 11'($urandom_range(0, 2047));
      col = 11'($urandom_range(0, 2047));
      wd  = 8'($urandom_range(0, 255));
      rd  = 8'($urandom_range(0, 254));
      we  = 1'($urandom_range(0, 1));
      c1  = 1'($urandom_range(0, 1));
      wn  = $urandom_range(0, TMO - 1);
      start_row(row);
      do_cas(col, c1, we, wd, wn, 1, rd, 0, ps, wt, ac, tp, te, hung);
      n_checks++;
      if (hung || wt != wn + 2 || (!we && data_in !== rd)) begin
        n_fail++;
        $display("FAIL random_%0d: got hung=%0d n_wait_low=%0d data_in=%h expected 0/%0d/%h",
                 k, hung, wt, data_in, wn + 2, rd);
      end
      check_sb("random");
      end_window();
    end
  endtask

  task automatic test_abort_nren();
    int ps, wt, ac, tp, te; bit hung;
    start_row(11'h003);
    do_cas(11'h040, 0, 0, 8'h00, 2, 1, 8'h3C, 1, ps, wt, ac, tp, te, hung);
    n_checks++;
    if (hung || ac != 3 || data_in !== 8'h3C) begin
      n_fail++;
      $display("FAIL abort_nren_complete: got hung=%0d access=%0d data_in=%h expected 0/3/3C", hung, ac, data_in);
    end
    @(negedge clk);
    n_checks++;
    if (state_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL abort_nren_idle: got state %0d expected 0", state_dbg);
    end
    check_sb("abort_nren");
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int ps, wt, ac, tp, te; bit hung;
    int cnt;
    start_row(11'h005);
    exp_q.push_back({1'b1, 8'h05, 7'h20, 1'b0, 8'h99});
    addr = 11'h040; n_we = 1'b0; data_out = 8'h99; n_cas_0 = 1'b0;
    cnt = 0;
    while (!penable && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (!penable) begin
      n_fail++;
      $display("FAIL reset_abort_reach_access: got penable=%b expected 1", penable);
    end
    n_rst = 1'b0;
    #1;
    n_checks++;
    if (psel !== 1'b0 || penable !== 1'b0 || n_wait !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_abort_immediate: got psel=%b penable=%b n_wait=%b expected 0/0/1", psel, penable, n_wait);
    end
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clears_timeout: got %b expected 0", timeout_err);
    end
    check_sb("reset_abort");
    @(negedge clk);
    n_rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (psel) cnt++;
    end
    n_checks++;
    if (cnt != 0 || state_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_no_restart: got psel_cycles=%0d state=%0d expected 0/0", cnt, state_dbg);
    end
    n_cas_0 = 1'b1;
    end_window();
    start_row(11'h006);
    do_cas(11'h002, 0, 1, 8'hA5, 0, 1, 8'h00, 0, ps, wt, ac, tp, te, hung);
    n_checks++;
    if (hung || ps != 2) begin
      n_fail++;
      $display("FAIL reset_fresh_edge: got hung=%0d psel=%0d expected 0/2", hung, ps);
    end
    check_sb("after_reset");
    end_window();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_timeout();
    test_back_to_back();
    test_random();
    test_abort_nren();
    test_reset_abort();
    n_checks++;
    if (prot_err != 0 || exp_q.size() != 0 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL protocol: got prot_err=%0d leftover exp=%0d obs=%0d expected 0/0/0",
               prot_err, exp_q.size(), obs_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
